// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RISC16 instruction fields into 16-bit words and loads them into instruction memory
module instr_encoder_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_func,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [1:0]          code_q, code_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                op_illegal, op_itype, op_jump, imm_ok, addr_full, xfer;
    logic [1:0]          bad_code;
    logic [15:0]         enc_word;
    // opcode classification and immediate range check for the presented bundle
    always_comb begin
        op_illegal = (in_opcode == 4'b1010) || (in_opcode == 4'b1110) || (in_opcode == 4'b1111);
        op_itype   = (in_opcode == 4'b0000) || (in_opcode == 4'b0001) || (in_opcode == 4'b1011) || (in_opcode == 4'b1100);
        op_jump    = in_opcode == 4'b1101;
        imm_ok     = in_imm[11:6] == {6{in_imm[5]}};
        bad_code   = op_illegal ? 2'b01 : (op_itype && !imm_ok) ? 2'b10 : 2'b00;
        enc_word   = op_itype ? {in_opcode, in_rs, in_rt, in_imm[5:0]} :
                     op_jump  ? {in_opcode, in_imm} :
                                {in_opcode, in_rs, in_rt, in_rd, in_func};
        addr_full  = &addr_q;
        xfer       = in_valid && in_ready && !start;
    end
    // next-state: start dominates, then accept or reject the transferred bundle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        code_d  = code_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = LOAD;
            addr_d  = '0;
            count_d = '0;
            code_d  = 2'b00;
        end else if (xfer && bad_code != 2'b00) begin
            state_d = ERR;
            code_d  = bad_code;
        end else if (xfer) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc_word;
            count_d = count_q + CNT_ONE;
            addr_d  = addr_full ? addr_q : addr_q + ADDR_ONE;
            state_d = (in_last || addr_full) ? DONE : LOAD;
        end
    end
    // state and registered write port, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            code_q  <= 2'b00;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            code_q  <= code_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
    assign in_ready   = state_q == LOAD;
    assign done       = state_q == DONE;
    assign err        = state_q == ERR;
    assign err_code   = code_q;
    assign count      = count_q;
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed checks against a field-level encoding model
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic        in_ready, imem_we, done, err;
    logic [3:0]  in_opcode = '0;
    logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_func = '0;
    logic [11:0] in_imm = '0;
    logic [3:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [1:0]  err_code;
    logic [4:0]  count;
    int n_checks = 0, n_fail = 0;

    instr_encoder_loader #(.ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_func(in_func), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    // returns {err_code, word}; word is meaningful only when err_code is zero
    function automatic logic [17:0] ref_enc(input logic [3:0] op, input logic [2:0] rs, rt, rd, fn, input logic [11:0] imm);
        int o, simm, w;
        logic [1:0] c;
        o = int'(op);
        simm = int'(imm) >= 2048 ? int'(imm) - 4096 : int'(imm);
        c = 2'd0;
        w = 0;
        if (o == 10 || o == 14 || o == 15) c = 2'd1;
        else if (o == 0 || o == 1 || o == 11 || o == 12) begin
            if (simm < -32 || simm > 31) c = 2'd2;
            else w = o * 4096 + int'(rs) * 512 + int'(rt) * 64 + (simm & 63);
        end else if (o == 13) w = o * 4096 + int'(imm);
        else w = o * 4096 + int'(rs) * 512 + int'(rt) * 64 + int'(rd) * 8 + int'(fn);
        return {c, w[15:0]};
    endfunction

    // apply one cycle of inputs, then release start/valid just after the edge
    task automatic drive(input logic s, v, l, input logic [3:0] op, input logic [2:0] rs, rt, rd, fn, input logic [11:0] imm);
        start = s; in_valid = v; in_last = l; in_opcode = op;
        in_rs = rs; in_rt = rt; in_rd = rd; in_func = fn; in_imm = imm;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        n_checks += 8;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", imem_we); end
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        if (imem_wdata !== 16'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code got %b want 00", err_code); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        rst_n = 1'b1;
        drive(0, 1, 0, 4'h2, 1, 2, 3, 0, 0);
        n_checks += 2;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_we got %b want 0", imem_we); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL idle_ignore_count got %0d want 0", count); end
    endtask

    task automatic test_rtype;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_in_ready got %b want 1", in_ready); end
        drive(0, 1, 0, 4'h2, 1, 2, 3, 0, 0);
        n_checks += 4;
        if (imem_we !== 1'b1) begin n_fail++; $display("FAIL rtype_we got %b want 1", imem_we); end
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL rtype_addr got %h want 0", imem_addr); end
        if (imem_wdata !== 16'h2298) begin n_fail++; $display("FAIL rtype_wdata got %h want 2298", imem_wdata); end
        if (count !== 5'd1) begin n_fail++; $display("FAIL rtype_count got %0d want 1", count); end
    endtask

    task automatic test_lw_j;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'h0, 2, 1, 0, 0, 12'hFFE);
        n_checks += 2;
        if (imem_wdata !== 16'h047E) begin n_fail++; $display("FAIL lw_wdata got %h want 047e", imem_wdata); end
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL lw_addr got %h want 0", imem_addr); end
        drive(0, 1, 1, 4'hD, 0, 0, 0, 0, 12'h123);
        n_checks += 6;
        if (imem_we !== 1'b1) begin n_fail++; $display("FAIL j_we got %b want 1", imem_we); end
        if (imem_wdata !== 16'hD123) begin n_fail++; $display("FAIL j_wdata got %h want d123", imem_wdata); end
        if (imem_addr !== 4'd1) begin n_fail++; $display("FAIL j_addr got %h want 1", imem_addr); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL j_done got %b want 1", done); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL j_in_ready got %b want 0", in_ready); end
        if (count !== 5'd2) begin n_fail++; $display("FAIL j_count got %0d want 2", count); end
        drive(0, 1, 0, 4'h3, 7, 7, 7, 7, 0);
        n_checks += 3;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL done_ignore_we got %b want 0", imem_we); end
        if (imem_wdata !== 16'hD123) begin n_fail++; $display("FAIL wdata_hold got %h want d123", imem_wdata); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got %b want 1", done); end
    endtask

    task automatic test_illegal_op;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'hE, 1, 1, 1, 1, 0);
        n_checks += 5;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL illop_we got %b want 0", imem_we); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL illop_err got %b want 1", err); end
        if (err_code !== 2'b01) begin n_fail++; $display("FAIL illop_code got %b want 01", err_code); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL illop_in_ready got %b want 0", in_ready); end
        if (count !== 5'd1) begin n_fail++; $display("FAIL illop_count got %0d want 1", count); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks += 3;
        if (err !== 1'b0) begin n_fail++; $display("FAIL restart_err got %b want 0", err); end
        if (err_code !== 2'b00) begin n_fail++; $display("FAIL restart_code got %b want 00", err_code); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL restart_count got %0d want 0", count); end
        drive(0, 1, 0, 4'h9, 4, 5, 6, 7, 0);
        n_checks += 2;
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL restart_addr got %h want 0", imem_addr); end
        if (imem_wdata !== ref_enc(4'h9, 4, 5, 6, 7, 0) >> 0 & 18'h0FFFF) begin n_fail++; $display("FAIL restart_wdata got %h", imem_wdata); end
    endtask

    task automatic test_imm_range;
        logic [17:0] r;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'hB, 3, 4, 0, 0, 12'h040);
        n_checks += 2;
        if (err_code !== 2'b10) begin n_fail++; $display("FAIL imm_hi_code got %b want 10", err_code); end
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL imm_hi_we got %b want 0", imem_we); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'hB, 3, 4, 0, 0, 12'hFE0);
        r = ref_enc(4'hB, 3, 4, 0, 0, 12'hFE0);
        n_checks += 3;
        if (imem_we !== 1'b1) begin n_fail++; $display("FAIL imm_lo_we got %b want 1", imem_we); end
        if (imem_wdata !== r[15:0]) begin n_fail++; $display("FAIL imm_lo_wdata got %h want %h", imem_wdata, r[15:0]); end
        if (imem_wdata[5:0] !== 6'b100000) begin n_fail++; $display("FAIL imm_lo_field got %b want 100000", imem_wdata[5:0]); end
        drive(0, 1, 0, 4'h1, 0, 0, 0, 0, 12'h01F);
        r = ref_enc(4'h1, 0, 0, 0, 0, 12'h01F);
        n_checks++;
        if (imem_wdata !== r[15:0]) begin n_fail++; $display("FAIL imm_31_wdata got %h want %h", imem_wdata, r[15:0]); end
        drive(0, 1, 0, 4'hF, 0, 0, 0, 0, 12'h400);
        n_checks++;
        if (err_code !== 2'b01) begin n_fail++; $display("FAIL op_priority_code got %b want 01", err_code); end
    endtask

    task automatic test_fill;
        logic [17:0] r;
        logic [3:0] op;
        logic [2:0] a, b, c, d;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(2, 9)); a = 3'($urandom); b = 3'($urandom); c = 3'($urandom); d = 3'($urandom);
            r = ref_enc(op, a, b, c, d, 0);
            drive(0, 1, 0, op, a, b, c, d, 0);
            n_checks += 3;
            if (imem_we !== 1'b1) begin n_fail++; $display("FAIL fill_we[%0d] got %b want 1", i, imem_we); end
            if (imem_addr !== 4'(i)) begin n_fail++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, imem_addr, i); end
            if (imem_wdata !== r[15:0]) begin n_fail++; $display("FAIL fill_wdata[%0d] got %h want %h", i, imem_wdata, r[15:0]); end
        end
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL fill_done got %b want 1", done); end
        if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", count); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        drive(0, 1, 0, 4'h2, 1, 1, 1, 1, 0);
        n_checks += 2;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL full_ignore_we got %b want 0", imem_we); end
        if (count !== 5'd16) begin n_fail++; $display("FAIL full_ignore_count got %0d want 16", count); end
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 4'h4, 3'(i), 1, 2, 3, 0);
        in_valid = 1'b1; in_opcode = 4'h5;
        #2 rst_n = 1'b0;
        #1;
        n_checks += 8;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b want 0", imem_we); end
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL mid_rst_addr got %h want 0", imem_addr); end
        if (imem_wdata !== 16'd0) begin n_fail++; $display("FAIL mid_rst_wdata got %h want 0", imem_wdata); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", done); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", err); end
        if (err_code !== 2'b00) begin n_fail++; $display("FAIL mid_rst_code got %b want 00", err_code); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", count); end
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1;
        drive(1, 1, 0, 4'h2, 1, 2, 3, 0, 0);
        n_checks += 3;
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL start_win_we got %b want 0", imem_we); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL start_win_count got %0d want 0", count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_win_in_ready got %b want 1", in_ready); end
        drive(0, 1, 0, 4'h2, 1, 2, 3, 0, 0);
        n_checks += 2;
        if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL start_win_addr got %h want 0", imem_addr); end
        if (imem_wdata !== 16'h2298) begin n_fail++; $display("FAIL start_win_wdata got %h want 2298", imem_wdata); end
    endtask

    task automatic test_random;
        int st, addr, cnt;
        logic [1:0] code;
        logic [17:0] r;
        logic s, v, l, ewe;
        logic [3:0] op, eaddr;
        logic [2:0] a, b, c, d;
        logic [11:0] imm;
        logic [15:0] edata;
        st = 0; addr = 0; cnt = 0; code = 0; eaddr = 0; edata = 0;
        for (int i = 0; i < 400; i++) begin
            s = (i == 0) || ($urandom_range(0, 19) == 0);
            v = $urandom_range(0, 3) != 0;
            l = $urandom_range(0, 15) == 0;
            op = 4'($urandom); a = 3'($urandom); b = 3'($urandom); c = 3'($urandom); d = 3'($urandom);
            imm = $urandom_range(0, 1) ? 12'($urandom_range(0, 63) - 32) : 12'($urandom);
            ewe = 1'b0;
            if (s) begin st = 1; addr = 0; cnt = 0; code = 0; end
            else if (v && st == 1) begin
                r = ref_enc(op, a, b, c, d, imm);
                if (r[17:16] != 2'd0) begin st = 3; code = r[17:16]; end
                else begin
                    ewe = 1'b1; eaddr = 4'(addr); edata = r[15:0]; cnt++;
                    if (l || addr == 15) st = 2; else addr++;
                end
            end
            drive(s, v, l, op, a, b, c, d, imm);
            n_checks += 6;
            if (imem_we !== ewe) begin n_fail++; $display("FAIL rnd_we[%0d] got %b want %b", i, imem_we, ewe); end
            if (count !== 5'(cnt)) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, cnt); end
            if (in_ready !== (st == 1)) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b", i, in_ready); end
            if (done !== (st == 2)) begin n_fail++; $display("FAIL rnd_done[%0d] got %b", i, done); end
            if (err !== (st == 3)) begin n_fail++; $display("FAIL rnd_err[%0d] got %b", i, err); end
            if (err_code !== code) begin n_fail++; $display("FAIL rnd_code[%0d] got %b want %b", i, err_code, code); end
            if (ewe) begin
                n_checks += 2;
                if (imem_addr !== eaddr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, eaddr); end
                if (imem_wdata !== edata) begin n_fail++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, imem_wdata, edata); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_lw_j;
        test_illegal_op;
        test_imm_range;
        test_fill;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Writer-side counterpart to the RISC16 opcode decoder. Accepts instruction fields over a valid/ready handshake and packs them into 16-bit RISC16 instruction words in the exact format the control unit decodes. Rejects illegal opcodes and out-of-range immediates. Writes accepted words into instruction memory at sequential addresses, acting as the program loader ahead of the fetch path.

## Interface
- ADDR_W, 4: instruction memory address width; depth = 2^ADDR_W words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears address, count and error, and enters LOAD.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_last  in  1  marks the final instruction of the program.
- in_opcode  in  4  opcode.
- in_rs, in_rt, in_rd, in_func  in  3 each  register and function fields.
- in_imm  in  12  immediate, two's complement.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  encoded instruction.
- done  out  1  program loaded; sticky until start.
- err  out  1  load aborted; sticky until start.
- err_code  out  2  00 none, 01 illegal opcode, 10 immediate out of range.
- count  out  ADDR_W+1  number of words written.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: in_ready=1.
  - DONE: done=1.
  - ERR: err=1.
- in_ready is 1 only in LOAD and is decoded from state only. A transfer occurs when in_valid && in_ready at a rising edge.
- Encoding by opcode:
  - 0010–1001 (data processing): {op, rs, rt, rd, func}.
  - 0000 LW, 0001 SW, 1011 BEQ, 1100 BNE: {op, rs, rt, imm[5:0]}.
  - 1101 J: {op, imm[11:0]}.
- Illegal opcodes are 1010, 1110 and 1111.
- I-type range rule: imm[11:6] must equal six copies of imm[5], so the legal range is −32..+31. Otherwise err_code = 10.
- Legal transfer: the word is written at the current address, then the address and count increment.
  - Moves LOAD→DONE if in_last=1 or the address was 2^ADDR_W−1 (memory full). The address never wraps.
- Illegal transfer: no write. Moves LOAD→ERR and sets err_code.
  - Opcode checks take priority over immediate checks.
- start from any state: state→LOAD, address=0, count=0, done=0, err=0, err_code=00.
  - start wins over a simultaneous transfer; that bundle is not accepted.
- in_valid in IDLE, DONE or ERR is ignored.
- rst_n low at any time: returns immediately to IDLE and clears all outputs, abandoning any pending write.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, err_code=00, count=0.
- Latency: a transfer at edge k drives imem_we=1 with imem_addr and imem_wdata for exactly the cycle following edge k; count updates at edge k.
- Sustained throughput is one word per cycle; back-to-back transfers give a continuous imem_we train.
- At the edge of the terminating transfer:
  - in_ready drops.
  - done or err rises at the same edge.
  - For DONE, the final imem_we pulse occurs in the same cycle that done is first high.
- A start arriving in the cycle a write is being driven does not cancel that write.
- imem_wdata holds its last value when imem_we=0.

## Test plan
- Reset, then start, then R-type op=0010 rs=1 rt=2 rd=3 func=0 → imem_wdata=0x2298 at addr 0 one cycle after the transfer; count=1.
- LW with rs=2 rt=1 imm=0xFFE (−2) → 0x047E. Then J with imm=0x123 plus in_last → 0xD123 at addr 1; done=1; in_ready=0.
- Opcode 1110 → no imem_we, err=1, err_code=01. A later start clears err and count, and the next word goes to addr 0.
- BEQ with imm=0x040 → err_code=10, no write. BEQ with imm=0xFE0 (−32) → legal, 0xB??0 form with imm field 100000.
- 16 back-to-back legal words with ADDR_W=4 and no in_last → addresses 0..15, done after the 16th, count=16, in_ready=0; further in_valid is ignored.
- Assert rst_n low mid-load after 5 words → all outputs return to reset values immediately. start with simultaneous in_valid → bundle not accepted, addr=0.
